nios2_mul_seq: RTL and testbench



---
 rtl/nios2_mul_pkg.sv | 34 +++
 rtl/nios2_mul_pp16.sv | 28 ++
 rtl/nios2_mul_seq.sv | 152 +++++++++++++++
 tb/tb_nios2_mul_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared definitions for the iterative Nios II multiply sequencer.
//   - op encodings carried on A_mul_op
//   - sequencer state enum
//   - per-op latency (accept cycle = 0 to done cycle) and a lookup helper
package nios2_mul_pkg;

  localparam logic [1:0] MUL    = 2'b00;  // low word of product
  localparam logic [1:0] MULXSS = 2'b01;  // high word, a signed, b signed
  localparam logic [1:0] MULXSU = 2'b10;  // high word, a signed, b unsigned
  localparam logic [1:0] MULXUU = 2'b11;  // high word, both unsigned

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIX,
    DONE
  } state_e;

  localparam int LAT_MUL    = 5;
  localparam int LAT_MULXUU = 6;
  localparam int LAT_MULXSS = 7;
  localparam int LAT_MULXSU = 7;

  function automatic int op_latency(input logic [1:0] op);
    case (op)
      MUL:     return LAT_MUL;
      MULXUU:  return LAT_MULXUU;
      MULXSS:  return LAT_MULXSS;
      default: return LAT_MULXSU;
    endcase
  endfunction

endpackage

// File: rtl/nios2_mul_pp16.sv
// nios2_mul_pp16: 16x16 unsigned multiplier with a registered 32-bit product.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high clear of the product register
//   a_i    - 16-bit multiplicand
//   b_i    - 16-bit multiplier
//   p_o    - product of the operands presented on the previous rising edge
module nios2_mul_pp16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [31:0] p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q <= 32'd0;
    end else begin
      p_q <= {16'd0, a_i} * {16'd0, b_i};
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: iterative 32x32 multiply built from four 16x16 partial
// products issued one per cycle into a single registered multiplier.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   A_mul_src1/src2    - operands a/b, captured on an accepted start
//   A_mul_op           - 00 mul, 01 mulxss, 10 mulxsu, 11 mulxuu
//   A_mul_start        - request, accepted only while idle
//   A_mul_busy         - high from the cycle after acceptance through DONE
//   A_mul_done         - one-cycle pulse in DONE
//   A_mul_seq_result   - result, held until the next completion
module nios2_mul_seq
  import nios2_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A_mul_src1,
  input  logic [31:0] A_mul_src2,
  input  logic [1:0]  A_mul_op,
  input  logic        A_mul_start,
  output logic        A_mul_busy,
  output logic        A_mul_done,
  output logic [31:0] A_mul_seq_result
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  // Tag of the product currently sitting in the multiplier register.
  logic        pend_valid_q, pend_valid_d;
  logic [1:0]  pend_k_q, pend_k_d;

  logic [15:0] mul_a, mul_b;
  logic [31:0] pp;
  logic [63:0] pp_shifted;
  logic [31:0] corr;

  nios2_mul_pp16 u_pp16 (
    .clk   (clk),
    .reset (reset),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (pp)
  );

  // Weight of the returned product: aL*bL -> 0, cross terms -> 16, aH*bH -> 32.
  always_comb begin
    pp_shifted = 64'd0;
    case (pend_k_q)
      2'd0:    pp_shifted = {32'd0, pp};
      2'd1,
      2'd2:    pp_shifted = {16'd0, pp, 16'd0};
      default: pp_shifted = {pp, 32'd0};
    endcase
  end

  // Signed correction of the unsigned high word: subtract b when a is
  // negative, and a when b is negative (signed b only).
  assign corr = (a_q[31] ? b_q : 32'd0)
              + ((b_q[31] && (op_q == MULXSS)) ? a_q : 32'd0);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    pend_valid_d = 1'b0;
    pend_k_d     = k_q;
    mul_a        = 16'd0;
    mul_b        = 16'd0;
    acc_d        = pend_valid_q ? (acc_q + pp_shifted) : acc_q;

    case (state_q)
      IDLE: begin
        if (A_mul_start) begin
          a_d     = A_mul_src1;
          b_d     = A_mul_src2;
          op_d    = A_mul_op;
          acc_d   = 64'd0;
          k_d     = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // k[0] picks the half of a, k[1] the half of b.
        mul_a        = k_q[0] ? a_q[31:16] : a_q[15:0];
        mul_b        = k_q[1] ? b_q[31:16] : b_q[15:0];
        pend_valid_d = 1'b1;
        pend_k_d     = k_q;
        // aH*bH only lands in bits [63:32], which mul never returns.
        if ((k_q == 2'd3) || ((k_q == 2'd2) && (op_q == MUL))) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        if ((op_q == MULXSS) || (op_q == MULXSU)) begin
          state_d = FIX;
        end else begin
          state_d  = DONE;
          result_d = (op_q == MUL) ? acc_d[31:0] : acc_d[63:32];
        end
      end
      FIX: begin
        acc_d[63:32] = acc_q[63:32] - corr;
        result_d     = acc_d[63:32];
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= MUL;
      acc_q        <= 64'd0;
      result_q     <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_k_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      pend_valid_q <= pend_valid_d;
      pend_k_q     <= pend_k_d;
    end
  end

  assign A_mul_busy       = (state_q != IDLE);
  assign A_mul_done       = (state_q == DONE);
  assign A_mul_seq_result = result_q;

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Testbench for nios2_mul_seq: directed table, start-held and mid-op reset
// sequences, then a randomized sweep against a 64-bit arithmetic model.
module tb_nios2_mul_seq;
  import nios2_mul_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [1:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  nios2_mul_seq dut (
    .clk              (clk),
    .reset            (reset),
    .A_mul_src1       (src1),
    .A_mul_src2       (src2),
    .A_mul_op         (op),
    .A_mul_start      (start),
    .A_mul_busy       (busy),
    .A_mul_done       (done),
    .A_mul_seq_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Reference: signed/unsigned 64-bit product straight from the op meaning.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MUL:     begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      MULXSS:  begin p = 64'(sa * sb); return p[63:32]; end
      MULXSU:  begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [31:0] exp, input string tag);
    int cyc;
    src1 = a; src2 = b; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, cyc, op_latency(o));
    check({tag, "_result"}, result, exp);
    $display("op=%0d a=%h b=%h result=%h exp=%h cycles=%0d", o, a, b, result, exp, cyc);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] corners[5];

  initial begin
    logic [31:0] ra, rb, e1, e2;
    logic [1:0]  ro;

    vecs[0] = '{32'h00010003, 32'h00020005, MUL,    32'h000B000F};
    vecs[1] = '{32'h00010003, 32'h00020005, MULXUU, 32'h00000002};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULXUU, 32'hFFFFFFFE};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULXSU, 32'hFFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, MULXSS, 32'h00000000};
    vecs[5] = '{32'h80000000, 32'h80000000, MULXSS, 32'h40000000};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, MULXUU, 32'h0B00EA4E};
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFFFFFF;
    corners[3] = 32'h80000000; corners[4] = 32'hFFFFFFFF;

    reset = 1'b1; start = 1'b0; src1 = '0; src2 = '0; op = MUL;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start held high through a mulxss; second op accepted the cycle after DONE
    e1 = ref_mul(32'hFFFFFFFF, 32'h00000002, MULXSS);
    e2 = ref_mul(32'h00000003, 32'h80000000, MULXSS);
    src1 = 32'hFFFFFFFF; src2 = 32'h00000002; op = MULXSS; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin src1 = 32'h00000003; src2 = 32'h80000000; end
      if (c == 7) begin
        check("hold_done1", {31'd0, done}, 32'd1);
        check("hold_result1", result, e1);
      end else if (c == 8) begin
        check("hold_idle_gap", {31'd0, busy}, 32'd0);
        check("hold_result_gap", result, e1);
      end else if (c > 8 && c < 15) begin
        check($sformatf("hold_busy_c%0d", c), {31'd0, busy}, 32'd1);
        check($sformatf("hold_nodone_c%0d", c), {31'd0, done}, 32'd0);
        check($sformatf("hold_keep_c%0d", c), result, e1);
      end else if (c == 15) begin
        check("hold_done2", {31'd0, done}, 32'd1);
        check("hold_result2", result, e2);
        start = 1'b0;
      end else begin
        check($sformatf("hold_early_c%0d", c), {31'd0, done}, 32'd0);
      end
    end
    $display("held-start sequence result1=%h result2=%h", e1, e2);
    @(posedge clk); #1;

    // Reset in ISSUE k=2 (cycle 3), then a clean mulxuu
    src1 = 32'h00000007; src2 = 32'h00000009; op = MULXUU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    $display("mid-op reset busy=%0d done=%0d result=%h", busy, done, result);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(32'h12345678, 32'h9ABCDEF0, MULXUU, 32'h0B00EA4E, "post_rst");

    // Random sweep against the reference model
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      ro = 2'($urandom_range(0, 3));
      do_op(ra, rb, ro, ref_mul(ra, rb, ro), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
